// File: rtl/pfreq_sink.sv
// Prefetch request sink: drops recently seen lines, queues the rest in a small
// FIFO and issues them to the cache prefetch port, with saturating statistics.
module pfreq_sink #(
  parameter int AW        = 39,
  parameter int LINE_BITS = 6,
  parameter int DEPTH     = 4,
  parameter int FILTER    = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pfreq_valid,
  output logic          pfreq_retry,
  input  logic [AW-1:0] pfreq_laddr,
  output logic          dcreq_valid,
  input  logic          dcreq_retry,
  output logic [AW-1:0] dcreq_laddr,
  input  logic          stats_clear,
  output logic [CW-1:0] stat_accepted,
  output logic [CW-1:0] stat_dup,
  output logic [CW-1:0] stat_issued,
  output logic          pf_busy
);

  localparam int LW   = AW - LINE_BITS;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int FPW  = (FILTER > 1) ? $clog2(FILTER) : 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [LW-1:0]   mem_r [DEPTH];
  logic [PW-1:0]   head_r, tail_r;
  logic [CNTW-1:0] count_r;
  logic            flt_vld_r  [FILTER];
  logic [LW-1:0]   flt_line_r [FILTER];
  logic [FPW-1:0]  flt_ptr_r;
  logic [CW-1:0]   acc_r, dup_r, iss_r;

  logic [LW-1:0] line_s;
  logic          xfer_s, hit_s, push_s, pop_s;

  assign line_s      = pfreq_laddr[AW-1:LINE_BITS];
  assign pfreq_retry = (count_r == CNTW'(DEPTH));
  assign dcreq_valid = (count_r != CNTW'(0));
  assign pf_busy     = dcreq_valid;
  // Gate the head so a stale, unreset entry never shows on an idle port.
  assign dcreq_laddr = dcreq_valid ? {mem_r[head_r], {LINE_BITS{1'b0}}} : {AW{1'b0}};
  assign stat_accepted = acc_r;
  assign stat_dup      = dup_r;
  assign stat_issued   = iss_r;

  // Handshake decode and recent-line filter lookup
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < FILTER; i++) begin
      hit_s = hit_s | (flt_vld_r[i] && (flt_line_r[i] == line_s));
    end
    xfer_s = pfreq_valid && !pfreq_retry;
    push_s = xfer_s && !hit_s;
    pop_s  = dcreq_valid && !dcreq_retry;
  end

  // FIFO storage, written at the tail on each push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= line_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CNTW'(0);
    end else begin
      if (push_s) tail_r <= tail_r + PW'(1);
      if (pop_s)  head_r <= head_r + PW'(1);
      if (push_s && !pop_s)      count_r <= count_r + CNTW'(1);
      else if (pop_s && !push_s) count_r <= count_r - CNTW'(1);
      else                       count_r <= count_r;
    end
  end

  // Recent-line filter, filled round-robin on every enqueued line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_ptr_r <= FPW'(0);
      for (int i = 0; i < FILTER; i++) begin
        flt_vld_r[i]  <= 1'b0;
        flt_line_r[i] <= {LW{1'b0}};
      end
    end else if (push_s) begin
      flt_vld_r[flt_ptr_r]  <= 1'b1;
      flt_line_r[flt_ptr_r] <= line_s;
      flt_ptr_r <= (flt_ptr_r == FPW'(FILTER - 1)) ? FPW'(0) : flt_ptr_r + FPW'(1);
    end
  end

  // Saturating statistics; clear has priority over any increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= CW'(0);
      dup_r <= CW'(0);
      iss_r <= CW'(0);
    end else if (stats_clear) begin
      acc_r <= CW'(0);
      dup_r <= CW'(0);
      iss_r <= CW'(0);
    end else begin
      if (xfer_s)          acc_r <= sat_inc(acc_r);
      if (xfer_s && hit_s) dup_r <= sat_inc(dup_r);
      if (pop_s)           iss_r <= sat_inc(iss_r);
    end
  end

endmodule
